// File: rtl/reg_file_32.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_32
//  Brief    : Architectural register file, 2**ADDR_W x DATA_W.
//             Two combinational read ports and one synchronous write port.
//             Register 0 is hardwired to zero.
//             Optional macro REG_FILE_BYPASS_EN enables write-through
//             forwarding from busW to the read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_32 #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   input  logic [ADDR_W-1:0] rw,
   input  logic              we,
   input  logic [DATA_W-1:0] busW,
   output logic [DATA_W-1:0] busA,
   output logic [DATA_W-1:0] busB
);

   localparam int c_NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0] r_regs [c_NUM_REGS];
   logic              w_wr_valid;
   logic [DATA_W-1:0] w_bus_a;
   logic [DATA_W-1:0] w_bus_b;

   // A write is only meaningful to a non-zero register; index 0 never changes.
   assign w_wr_valid = we && (rw != '0);

   // Storage array: asynchronous clear, one write per rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_valid) begin
         r_regs[rw] <= busW;
      end
   end

   // Combinational read ports; the zero register overrides everything else.
   always_comb begin
      w_bus_a = '0;
      w_bus_b = '0;
      if (ra != '0) begin
         w_bus_a = r_regs[ra];
      end
      if (rb != '0) begin
         w_bus_b = r_regs[rb];
      end
`ifdef REG_FILE_BYPASS_EN
      // Forward the pending write-back so decode sees it in the same cycle.
      // Suppressed during reset because the write will be dropped.
      if (!rst && w_wr_valid && (ra == rw)) begin
         w_bus_a = busW;
      end
      if (!rst && w_wr_valid && (rb == rw)) begin
         w_bus_b = busW;
      end
`endif
   end

   assign busA = w_bus_a;
   assign busB = w_bus_b;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_32
//  Brief    : Scoreboard bench for reg_file_32. Stimulus pushes expected
//             read values into a queue; a monitor pops and compares.
//             Honours REG_FILE_BYPASS_EN for the same-cycle read/write case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_32;

   logic        clk;
   logic        rst;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [4:0]  rw;
   logic        we;
   logic [31:0] busW;
   logic [31:0] busA;
   logic [31:0] busB;

   typedef struct {
      string       name;
      logic [31:0] ea;
      logic [31:0] eb;
   } exp_t;

   exp_t sb[$];
   event sample_ev;
   int   vectors  = 0;
   int   miscomp  = 0;
   int   issued   = 0;
   int   popped   = 0;

   reg_file_32 #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk  (clk),
      .rst  (rst),
      .ra   (ra),
      .rb   (rb),
      .rw   (rw),
      .we   (we),
      .busW (busW),
      .busA (busA),
      .busB (busB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: each sample event means the read ports are settled.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         if (sb.size() == 0) begin
            miscomp++;
            vectors++;
            $display("FAIL scoreboard_underflow: got empty queue, required an entry");
         end else begin
            e = sb.pop_front();
            popped++;
            vectors++;
            if (busA !== e.ea) begin
               miscomp++;
               $display("FAIL %s busA: got %h required %h", e.name, busA, e.ea);
            end
            vectors++;
            if (busB !== e.eb) begin
               miscomp++;
               $display("FAIL %s busB: got %h required %h", e.name, busB, e.eb);
            end
         end
      end
   end

   // Drive read addresses, then hand the expectation to the monitor.
   task automatic sample(input string name, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      ra = a;
      rb = b;
      #1;
      e.name = name;
      e.ea   = ea;
      e.eb   = eb;
      sb.push_back(e);
      issued++;
      -> sample_ev;
      #1;
   endtask

   // One write straddling a single rising edge.
   task automatic wr(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      we   = 1'b1;
      rw   = addr;
      busW = data;
      @(negedge clk);
      we   = 1'b0;
   endtask

   logic [31:0] exp_a;
   logic [31:0] exp_b;

   initial begin
      rst  = 1'b1;
      we   = 1'b0;
      rw   = '0;
      busW = '0;
      ra   = '0;
      rb   = '0;

      // Reset state
      @(negedge clk);
      sample("reset_state", 5'd5, 5'd31, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-cycle after a write
      wr(5'd5, 32'hDEADBEEF);
      sample("r5_written", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
      @(negedge clk);
      #1 rst = 1'b1;
      sample("async_reset_immediate", 5'd5, 5'd5, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      sample("after_reset_release", 5'd5, 5'd5, 32'h0, 32'h0);

      // Reset beats a pending write
      @(negedge clk);
      we = 1'b1; rw = 5'd6; busW = 32'h66666666;
      #1 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      we  = 1'b0;
      sample("reset_wins_write", 5'd6, 5'd6, 32'h0, 32'h0);

      // Basic write/read
      wr(5'd7, 32'h12345678);
      sample("basic_rw", 5'd7, 5'd7, 32'h12345678, 32'h12345678);

      // Zero register discards writes
      wr(5'd0, 32'hFFFFFFFF);
      sample("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

      // Write enable low leaves state alone, also with X on rw/busW
      wr(5'd3, 32'h00000011);
      @(negedge clk);
      we = 1'b0; rw = 5'd3; busW = 32'hAAAA5555;
      @(negedge clk);
      sample("we_low", 5'd3, 5'd7, 32'h00000011, 32'h12345678);
      rw = 'x; busW = 'x;
      @(negedge clk);
      @(negedge clk);
      sample("x_with_we_low", 5'd3, 5'd7, 32'h00000011, 32'h12345678);
      rw = '0; busW = '0;

      // Same-cycle read/write of r9
      wr(5'd9, 32'h1);
      @(negedge clk);
      we = 1'b1; rw = 5'd9; busW = 32'h2;
`ifdef REG_FILE_BYPASS_EN
      sample("same_cycle_before_edge", 5'd9, 5'd3, 32'h2, 32'h00000011);
`else
      sample("same_cycle_before_edge", 5'd9, 5'd3, 32'h1, 32'h00000011);
`endif
      @(negedge clk);
      we = 1'b0;
      sample("same_cycle_after_edge", 5'd9, 5'd9, 32'h2, 32'h2);

      // Full sweep
      for (int i = 1; i < 32; i++) begin
         wr(5'(i), 32'(i) * 32'h01010101);
      end
      for (int i = 0; i < 32; i++) begin
         exp_a = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
         exp_b = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101;
         @(negedge clk);
         sample($sformatf("sweep_%0d", i), 5'(i), 5'(31 - i), exp_a, exp_b);
      end

      @(negedge clk);
      vectors++;
      if (popped != issued) begin
         miscomp++;
         $display("FAIL scoreboard_drain: got %0d checked required %0d issued", popped, issued);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
      $finish;
   end

   // Global time bound so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/reg_file_32.md
Name: reg_file_32

Overview:
- Architectural register file for the single-cycle datapath.
- Sits directly upstream of the execute stage and drives its busA and busB operand inputs.
- Accepts one write-back per cycle from the writeback stage (ALU/mult result or load data).
- Provides two combinational reads; register 0 is hardwired to zero.

Parameters:
DATA_W, 32, width of each register and of all data buses
ADDR_W, 5, register index width; register count = 2**ADDR_W (32)

Ports:
clk  input  1  system clock; all writes occur on its rising edge
rst  input  1  asynchronous, active-high reset; clears every register
ra  input  ADDR_W  read address for port A (instruction rs field)
rb  input  ADDR_W  read address for port B (instruction rt field)
rw  input  ADDR_W  write address (rd, rt, or 31 for link, chosen upstream)
we  input  1  write enable (RegWr from control)
busW  input  DATA_W  write data from writeback
busA  output  DATA_W  contents of register ra, feeds execute busA
busB  output  DATA_W  contents of register rb, feeds execute busB

Behaviour:
- Storage: 32 x DATA_W flop array, regs[0..31].
- Reset: rst high clears all regs to 0 immediately, without waiting for clk. While rst is high, busA = busB = 0 and writes are ignored.
- Deassertion of rst is sampled normally; the first write can occur on the first rising clk edge with rst low.
- Write: on rising clk, if rst low and we high and rw != 0, then regs[rw] <= busW. Latency is 1 edge.
- Writes with rw == 0 are discarded; regs[0] stays 0 permanently.
- Read: fully combinational, zero latency.
  - busA = (ra == 0) ? 0 : regs[ra]
  - busB = (rb == 0) ? 0 : regs[rb]
- Read/write same cycle, same address (macro absent): the read returns the old value until the edge; the new value is visible after the edge.
- ra == rb is legal; both ports return the same value.
- we low: no state change regardless of rw and busW.
- Reset asserted mid-cycle while we is high: reset wins and the pending write is lost.
- X on rw or busW while we is low must not corrupt state.
- No internal state machine beyond the storage array. The single-cycle core relies on the combinational read path, so the array must not be registered on the read side.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If we high, rw != 0 and ra == rw, then busA = busW in the same cycle. Likewise for busB when rb == rw.
  - The zero-register rule still takes priority.
  - Used when the team moves to the pipelined core (write-back and decode in the same cycle).
- Undefined: no forwarding path; reads always reflect the array contents as stated above.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing 0xDEADBEEF to r5 -> busA (ra=5) reads 0 immediately, before the next clk edge; r5 reads 0 after rst drops.
- Basic write/read: we=1, rw=7, busW=0x12345678, one edge -> ra=7 gives busA=0x12345678 and rb=7 gives busB=0x12345678 on the same cycle.
- Zero register: we=1, rw=0, busW=0xFFFFFFFF, edge -> ra=0 and rb=0 both give 0.
- Write enable: we=0, rw=3, busW=0xAAAA5555, edge -> r3 keeps its prior value 0x00000011.
- Same-cycle read/write: r9=0x1, we=1, rw=9, busW=0x2, ra=9 before edge.
  - Macro absent -> busA=0x1.
  - REG_FILE_BYPASS_EN defined -> busA=0x2.
  - Both builds -> busA=0x2 after the edge.
- Full sweep: write regs[i]=i*0x01010101 for i=1..31, then read all pairs (i, 31-i) -> both ports return the expected values; r0 returns 0.
